// File: rtl/lsu_pkg.sv
// Shared constants and types for the RV32I load/store unit.
package lsu_pkg;

    // RV32I funct3 encodings for loads and stores
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // data_mem width_sel codes
    localparam logic [2:0] W_B  = 3'b000;
    localparam logic [2:0] W_H  = 3'b001;
    localparam logic [2:0] W_W  = 3'b010;
    localparam logic [2:0] W_BU = 3'b011;
    localparam logic [2:0] W_HU = 3'b100;

    // Response fault codes
    localparam logic [1:0] FLT_OK       = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_RANGE    = 2'b10;
    localparam logic [1:0] FLT_FUNCT3   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Zero the store-data bytes above the access width so data_mem sees clean data.
    function automatic logic [31:0] mask_wdata(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] res;
        case (funct3)
            F3_SB:   res = {24'h0, wdata[7:0]};
            F3_SH:   res = {16'h0, wdata[15:0]};
            default: res = wdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_req_check.sv
// Combinational request checker: fault classification and funct3 -> width_sel.
module lsu_req_check
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    output logic [1:0]  fault,
    output logic [2:0]  width_sel
);

    logic legal;
    logic misaligned;
    logic out_of_range;

    // Decode funct3 into legality and width, then apply fault priority.
    always_comb begin
        legal     = 1'b0;
        width_sel = W_B;
        // Store encodings share values with LB/LH/LW; only the unsigned forms are load-only.
        case (funct3)
            F3_LB:   begin legal = 1'b1;   width_sel = W_B;  end
            F3_LH:   begin legal = 1'b1;   width_sel = W_H;  end
            F3_LW:   begin legal = 1'b1;   width_sel = W_W;  end
            F3_LBU:  begin legal = ~store; width_sel = W_BU; end
            F3_LHU:  begin legal = ~store; width_sel = W_HU; end
            default: begin legal = 1'b0;   width_sel = W_B;  end
        endcase

        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = |addr[1:0];
            default: misaligned = 1'b0;
        endcase

        out_of_range = (addr >> ADDR_W) != 32'd0;

        if (!legal)
            fault = FLT_FUNCT3;
        else if (misaligned)
            fault = FLT_MISALIGN;
        else if (out_of_range)
            fault = FLT_RANGE;
        else
            fault = FLT_OK;
    end

endmodule

// File: rtl/lsu_rv32i.sv
// RV32I load/store unit: accepts one request, drives data_mem for one cycle,
// waits out the read latency and returns a single response pulse.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_* are sampled only on that edge. rsp_valid is
// a one-cycle pulse with no back-pressure.
module lsu_rv32i
    import lsu_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    output logic [4:0]        rsp_rd,
    output logic [31:0]       rsp_data,
    output logic [1:0]        rsp_fault,
    output logic              mem_we,
    output logic              mem_re,
    output logic [2:0]        mem_width_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);

    state_t           state;
    logic             ready_q;
    logic             rsp_valid_q;
    logic             is_store_q;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       chk_fault;
    logic [2:0]       chk_width;

    lsu_req_check #(.ADDR_W(ADDR_W)) u_check (
        .store     (req_store),
        .funct3    (req_funct3),
        .addr      (req_addr),
        .fault     (chk_fault),
        .width_sel (chk_width)
    );

    // ready_q is high only in IDLE, and not in the first cycle after reset release.
    assign req_ready = ready_q & ~flush;
    // A flush in the response cycle cancels the pulse.
    assign rsp_valid = rsp_valid_q & ~flush;

    // Transaction FSM with registered memory and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ready_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            is_store_q    <= 1'b0;
            rd_q          <= 5'd0;
            cnt           <= '0;
            rsp_rd        <= 5'd0;
            rsp_data      <= 32'd0;
            rsp_fault     <= FLT_OK;
            mem_we        <= 1'b0;
            mem_re        <= 1'b0;
            mem_width_sel <= 3'd0;
            mem_addr      <= '0;
            mem_wdata     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid && req_ready) begin
                        ready_q <= 1'b0;
                        if (chk_fault != FLT_OK) begin
                            state       <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_fault   <= chk_fault;
                            rsp_rd      <= 5'd0;
                            rsp_data    <= 32'd0;
                        end else begin
                            state         <= S_ISSUE;
                            mem_addr      <= req_addr[ADDR_W-1:0];
                            mem_width_sel <= chk_width;
                            mem_we        <= req_store;
                            mem_re        <= ~req_store;
                            mem_wdata     <= req_store ? mask_wdata(req_funct3, req_wdata) : 32'd0;
                            is_store_q    <= req_store;
                            rd_q          <= req_rd;
                        end
                    end
                end
                S_ISSUE: begin
                    // data_mem acts on this edge, so the strobe completes even under flush.
                    mem_we <= 1'b0;
                    mem_re <= 1'b0;
                    if (flush) begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                    end else if (is_store_q) begin
                        state       <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_fault   <= FLT_OK;
                        rsp_rd      <= 5'd0;
                        rsp_data    <= 32'd0;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= CNT_W'(LOAD_LAT);
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (flush) begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                    end else if (cnt == CNT_W'(1)) begin
                        state       <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_fault   <= FLT_OK;
                        rsp_rd      <= rd_q;
                        rsp_data    <= mem_rdata;
                    end
                end
                S_RESP: begin
                    state       <= S_IDLE;
                    ready_q     <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rd      <= 5'd0;
                    rsp_data    <= 32'd0;
                    rsp_fault   <= FLT_OK;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_rv32i.sv
// Bench for lsu_rv32i with a behavioural data_mem and a transaction-level reference model.
module tb_lsu_rv32i;

    localparam int ADDR_W   = 9;
    localparam int LOAD_LAT = 1;
    localparam int MEM_SZ   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_store = 1'b0;
    logic [2:0]        req_funct3 = 3'd0;
    logic [31:0]       req_addr = 32'd0;
    logic [31:0]       req_wdata = 32'd0;
    logic [4:0]        req_rd = 5'd0;
    logic              rsp_valid;
    logic [4:0]        rsp_rd;
    logic [31:0]       rsp_data;
    logic [1:0]        rsp_fault;
    logic              mem_we;
    logic              mem_re;
    logic [2:0]        mem_width_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    logic [7:0] dm     [0:MEM_SZ-1];
    logic [7:0] shadow [0:MEM_SZ-1];
    bit         dm_loaded = 1'b0;

    lsu_rv32i #(.ADDR_W(ADDR_W), .LOAD_LAT(LOAD_LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_store     (req_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rd        (req_rd),
        .rsp_valid     (rsp_valid),
        .rsp_rd        (rsp_rd),
        .rsp_data      (rsp_data),
        .rsp_fault     (rsp_fault),
        .mem_we        (mem_we),
        .mem_re        (mem_re),
        .mem_width_sel (mem_width_sel),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural data_mem ----------------
    function automatic logic [31:0] dm_read(input int a, input logic [2:0] ws);
        logic [31:0] w;
        w = {dm[(a + 3) % MEM_SZ], dm[(a + 2) % MEM_SZ], dm[(a + 1) % MEM_SZ], dm[a]};
        case (ws)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b010:  return w;
            3'b011:  return {24'h0, w[7:0]};
            3'b100:  return {16'h0, w[15:0]};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!dm_loaded) begin
            for (int i = 0; i < MEM_SZ; i++) dm[i] <= shadow[i];
            dm_loaded <= 1'b1;
        end else begin
            if (mem_we) begin
                dm[mem_addr] <= mem_wdata[7:0];
                if (mem_width_sel == 3'b001 || mem_width_sel == 3'b010)
                    dm[(int'(mem_addr) + 1) % MEM_SZ] <= mem_wdata[15:8];
                if (mem_width_sel == 3'b010) begin
                    dm[(int'(mem_addr) + 2) % MEM_SZ] <= mem_wdata[23:16];
                    dm[(int'(mem_addr) + 3) % MEM_SZ] <= mem_wdata[31:24];
                end
            end
            if (mem_re)
                mem_rdata <= dm_read(int'(mem_addr), mem_width_sel);
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [1:0] ref_fault(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        bit legal;
        int size;
        if (st) legal = (f3 <= 3'd2);
        else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = 1 << f3[1:0];
        if (!legal) return 2'd3;
        if ((addr % size) != 0) return 2'd1;
        if (addr >= MEM_SZ) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [2:0] ref_width(input logic [2:0] f3);
        case (f3)
            3'd4:    return 3'd3;
            3'd5:    return 3'd4;
            default: return f3;
        endcase
    endfunction

    function automatic logic [31:0] ref_mask(input logic [2:0] f3, input logic [31:0] wd);
        int size;
        size = 1 << f3[1:0];
        return 32'(((64'd1 << (8 * size)) - 64'd1) & {32'd0, wd});
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        int size;
        longint v;
        size = 1 << f3[1:0];
        v = 0;
        for (int i = 0; i < size; i++) v = v + (longint'(shadow[int'(addr) + i]) << (8 * i));
        if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int size;
        size = 1 << f3[1:0];
        for (int i = 0; i < size; i++) shadow[int'(addr) + i] = 8'(wd >> (8 * i));
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    // Present a request and return one tick after the edge it was accepted on.
    task automatic drive_accept(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [4:0] rd, output bit ok);
        int waited;
        waited = 0;
        req_valid = 1'b1; req_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wd; req_rd = rd;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        ok = req_ready;
        check("accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_store = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_rd = 5'($urandom);
    endtask

    // One full transaction, optionally flushed in cycle fcyc after acceptance (0 = none).
    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input int fcyc);
        logic [1:0]  ef;
        logic [31:0] exp_data;
        int          rcyc, exp_rdy, strobes, strobe_cyc, rsp_seen, rsp_cyc, rdy_cyc;
        bit          exp_mem, exp_rsp, ok;
        logic        got_we;
        logic [2:0]  got_w;
        logic [31:0] got_a, got_wd, got_data;
        logic [4:0]  got_rd;
        logic [1:0]  got_fault;

        ef       = ref_fault(st, f3, addr);
        exp_mem  = (ef == 2'd0);
        rcyc     = !exp_mem ? 1 : (st ? 2 : 2 + LOAD_LAT);
        exp_rsp  = (fcyc == 0);
        exp_rdy  = exp_rsp ? rcyc + 1 : fcyc + 1;
        exp_data = (exp_mem && !st) ? ref_load(f3, addr) : 32'd0;
        strobes = 0; strobe_cyc = 0; rsp_seen = 0; rsp_cyc = 0; rdy_cyc = 0;
        got_we = 0; got_w = 0; got_a = 0; got_wd = 0; got_data = 0; got_rd = 0; got_fault = 0;

        drive_accept(st, f3, addr, wd, rd, ok);
        if (!ok) return;

        for (int k = 1; k <= 8; k++) begin
            flush = (k == fcyc);
            @(negedge clk);
            if (mem_we || mem_re) begin
                strobes++;
                if (strobe_cyc == 0) begin
                    strobe_cyc = k; got_we = mem_we; got_w = mem_width_sel;
                    got_a = 32'(mem_addr); got_wd = mem_wdata;
                end
            end
            if (rsp_valid) begin
                rsp_seen++;
                rsp_cyc = k; got_data = rsp_data; got_rd = rsp_rd; got_fault = rsp_fault;
            end
            if (req_ready && rdy_cyc == 0) rdy_cyc = k;
            @(posedge clk);
            #1;
        end
        flush = 1'b0;

        check("strobes", 32'(strobes), exp_mem ? 32'd1 : 32'd0);
        if (strobes > 0) begin
            check("strobe_cyc", 32'(strobe_cyc), 32'd1);
            check("strobe_kind", 32'(got_we), 32'(st));
            check("width_sel", 32'(got_w), 32'(ref_width(f3)));
            check("mem_addr", got_a, addr & (MEM_SZ - 1));
            check("mem_wdata", got_wd, st ? ref_mask(f3, wd) : 32'd0);
        end
        check("rsp_count", 32'(rsp_seen), exp_rsp ? 32'd1 : 32'd0);
        if (rsp_seen > 0) begin
            check("rsp_cyc", 32'(rsp_cyc), 32'(rcyc));
            check("rsp_fault", 32'(got_fault), 32'(ef));
            check("rsp_rd", 32'(got_rd), (exp_mem && !st) ? 32'(rd) : 32'd0);
            check("rsp_data", got_data, exp_data);
        end
        check("ready_back", 32'(rdy_cyc), 32'(exp_rdy));
        if (exp_mem && st) ref_store(f3, addr, wd);
    endtask

    // Hold req_valid high and measure the spacing between acceptances.
    task automatic throughput(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int gap, input string tag);
        int last, n;
        last = -1; n = 0;
        req_valid = 1'b1; req_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wd; req_rd = 5'd9;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready) begin
                if (last >= 0) check(tag, 32'(k - last), 32'(gap));
                last = k;
                n++;
            end
            @(posedge clk);
        end
        #1;
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_count"}, 32'(n >= 4), 32'd1);
        if (st && ref_fault(st, f3, addr) == 2'd0) ref_store(f3, addr, wd);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctrl"}, {18'd0, req_ready, rsp_valid, mem_we, mem_re, rsp_fault, mem_width_sel, rsp_rd}, 32'd0);
        check({tag, "_rsp_data"}, rsp_data, 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("ready_after_release", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        for (int i = 0; i < MEM_SZ; i++) shadow[i] = 8'($urandom);

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        release_reset();

        // directed
        send(1'b1, 3'b010, 32'h010, 32'hA5A5_0010, 5'd0, 0);
        send(1'b0, 3'b010, 32'h010, 32'h0, 5'd5, 0);
        send(1'b1, 3'b000, 32'h011, 32'hDEAD_BE22, 5'd0, 0);
        send(1'b0, 3'b100, 32'h011, 32'h0, 5'd7, 0);
        send(1'b0, 3'b000, 32'h011, 32'h0, 5'd8, 0);
        send(1'b1, 3'b001, 32'h01E, 32'h1234_8765, 5'd0, 0);
        send(1'b0, 3'b001, 32'h01E, 32'h0, 5'd3, 0);
        send(1'b0, 3'b101, 32'h01E, 32'h0, 5'd4, 0);
        send(1'b0, 3'b010, 32'h002, 32'h0, 5'd6, 0);
        send(1'b0, 3'b001, 32'h200, 32'h0, 5'd6, 0);
        send(1'b0, 3'b111, 32'h010, 32'h0, 5'd6, 0);
        send(1'b1, 3'b011, 32'h010, 32'h0, 5'd6, 0);
        send(1'b1, 3'b100, 32'h010, 32'h0, 5'd6, 0);

        // flush cases
        send(1'b0, 3'b010, 32'h010, 32'h0, 5'd5, 1);
        send(1'b1, 3'b010, 32'h030, 32'hCAFE_F00D, 5'd0, 1);
        send(1'b0, 3'b010, 32'h030, 32'h0, 5'd2, 0);
        send(1'b0, 3'b010, 32'h030, 32'h0, 5'd2, 2);
        send(1'b0, 3'b010, 32'h030, 32'h0, 5'd2, 3);
        send(1'b1, 3'b000, 32'h031, 32'h0, 5'd0, 2);
        send(1'b0, 3'b111, 32'h030, 32'h0, 5'd2, 1);

        // reset while a store is being issued: the write is dropped
        drive_accept(1'b1, 3'b010, 32'h020, 32'h1122_3344, 5'd0, ok);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("rst_issue");
        release_reset();
        send(1'b0, 3'b010, 32'h020, 32'h0, 5'd1, 0);

        // reset while a load waits for data
        drive_accept(1'b0, 3'b010, 32'h008, 32'h0, 5'd9, ok);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_idle_outputs("rst_wait");
        release_reset();
        send(1'b0, 3'b010, 32'h004, 32'h0, 5'd10, 0);

        // throughput with req_valid held high
        throughput(1'b0, 3'b010, 32'h040, 32'h0, 4, "tput_load");
        throughput(1'b1, 3'b010, 32'h040, 32'h5566_7788, 3, "tput_store");
        throughput(1'b0, 3'b010, 32'h002, 32'h0, 2, "tput_fault");
        send(1'b0, 3'b010, 32'h040, 32'h0, 5'd11, 0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] addr;
            logic [1:0]  ef;
            int          rcyc, fcyc;
            st   = 1'($urandom);
            f3   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
            addr = 32'($urandom_range(0, MEM_SZ - 1));
            if ($urandom_range(0, 1) == 1) addr = addr & ~32'd3;
            if ($urandom_range(0, 7) == 0) addr = addr | (32'd1 << $urandom_range(ADDR_W, 31));
            ef   = ref_fault(st, f3, addr);
            rcyc = (ef != 2'd0) ? 1 : (st ? 2 : 2 + LOAD_LAT);
            fcyc = ($urandom_range(0, 4) == 0) ? $urandom_range(1, rcyc) : 0;
            send(st, f3, addr, $urandom, 5'($urandom), fcyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_rv32i.md
Name: lsu_rv32i

Overview:
- Load/store unit: the initiator side of the data_mem_rv32i interface.
- Accepts one memory request per transaction from the execute stage over a valid/ready handshake, and checks it for funct3 legality, alignment and range.
- Translates RV32I funct3 into the data_mem width_sel code and drives data_mem for one cycle.
- Waits out the synchronous read latency, then returns one response per accepted request to writeback.

Parameters:
- ADDR_W, 9, data_mem byte-address width; mem_addr = req_addr[ADDR_W-1:0].
- LOAD_LAT, 1, clock edges after the data_mem capture edge until mem_rdata is valid (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous pipeline flush; drops the pending response.
- req_valid  in  1  request valid.
- req_ready  out  1  LSU can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low-aligned.
- req_rd  in  5  load destination register.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rd  out  5  echoed rd; 0 for stores and faults.
- rsp_data  out  32  load data, already extended by data_mem; 0 for stores and faults.
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.
- mem_we  out  1  data_mem write strobe.
- mem_re  out  1  data_mem read strobe.
- mem_width_sel  out  3  data_mem width code.
- mem_addr  out  ADDR_W  data_mem byte address.
- mem_wdata  out  32  data_mem write data.
- mem_rdata  in  32  data_mem read data.

Behaviour:
- Reset:
  - rst_n low forces state IDLE and all outputs/registers to 0 immediately, including mem_we/mem_re (an in-flight write is dropped).
  - req_ready goes to 1 on the first clock after release.
- Outputs are registered; the mem_* signals change only on clk edges.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = ~flush.
  - Accept on req_valid & req_ready.
  - Fault check priority:
    - illegal funct3: loads {011,110,111}; stores ≥011.
    - misaligned: H needs addr[0]=0; W needs addr[1:0]=00.
    - out of range: req_addr[31:ADDR_W] != 0.
  - Faulted request: no memory access; go to RESP with fault code, rd 0, data 0.
  - Clean request: load mem_addr and mem_width_sel, raise mem_we or mem_re, go to ISSUE.
- Width translation (funct3 → width_sel):
  - 000→000 (LB/SB), 001→001 (LH/SH), 010→010 (LW/SW).
  - 100→011 (LBU), 101→100 (LHU).
- Store data masking:
  - SB: mem_wdata = {24'h0, wdata[7:0]}.
  - SH: mem_wdata = {16'h0, wdata[15:0]}.
  - SW: mem_wdata = wdata unchanged.
  - Loads: mem_wdata = 0.
- ISSUE:
  - mem strobe is high for exactly this cycle; data_mem acts on the closing edge.
  - Strobes drop on that edge.
  - Store → RESP (rd 0, data 0, fault 00).
  - Load → WAIT with counter = LOAD_LAT.
- WAIT:
  - Counter decrements each edge.
  - On the edge where the counter equals 1, capture mem_rdata into rsp_data and go to RESP.
- RESP: rsp_valid = 1 for one cycle, req_ready = 0; then IDLE.
- Latency (accept edge to rsp_valid cycle), LOAD_LAT = 1:
  - load: 2+LOAD_LAT = 3 cycles.
  - store: 2 cycles.
  - fault: 1 cycle.
- Throughput with req_valid held high: one load / 4 cycles, store / 3, fault / 2.
- flush:
  - In ISSUE: the strobe still completes (a store is committed); then IDLE, no response.
  - In WAIT or RESP: return to IDLE next edge; rsp_valid is suppressed in that cycle.
  - In IDLE: blocks acceptance.
- req_* inputs are sampled only at acceptance; later changes are ignored.
- A stall by the consumer is not supported: rsp_valid is fire-and-forget.

Decomposition:
- lsu_pkg holds:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - data_mem width codes (W_B=000, W_H=001, W_W=010, W_BU=011, W_HU=100).
  - fault codes.
  - state enum.
- One combinational sub-module, lsu_req_check: inputs store, funct3, addr; outputs fault[1:0] and width_sel[2:0]. The top module holds the FSM, counter and registers.

Test Plan:
- SW addr 0x010 wdata 0xA5A50010 → mem_we for one cycle, width 010, addr 0x010; rsp_valid 2 cycles later with fault 00. Then LW 0x010 rd=5 → mem_re for one cycle; rsp_valid 3 cycles after accept with data 0xA5A50010, rd 5.
- SB 0x011 wdata 0xDEADBE22 → mem_wdata 0x00000022, width 000. Then LBU (funct3 100) at 0x011 → mem_width_sel 011; rsp_data equals mem_rdata.
- LW at 0x002 → no strobe; rsp_valid the next cycle with fault 01, data 0, rd 0. LH at 0x200 → fault 10. Load funct3 111 → fault 11.
- Flush the cycle after accepting LW → mem_re pulses once, no rsp_valid, req_ready back 1 cycle later. Flush during ISSUE of SW → mem_we still pulses, no response.
- rst_n low in WAIT → all outputs 0 asynchronously. After release, LW 0x004 completes normally. Back-to-back LW with req_valid held → accepts exactly every 4 cycles.
